fetch_stage: RTL and testbench

- Instruction fetch stage of the 5-stage pipeline. Sits directly upstream of decode/register-read and produces the `pc` and `instruction` pair that decode consumes.
- Owns the 12-bit PC register and drives the synchronous instruction ROM address.
- Applies redirects: jumps resolved in decode, and taken branches or register jumps resolved in execute. Holds on pipeline stall.
- Squashes the wrong-path instruction when execute redirects.

---
 rtl/fetch_stage.sv | 96 +++++++++
 tb/tb_fetch_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage of the 5-stage pipeline. Owns the PC register and
// drives the address of the synchronous instruction ROM. Presents a
// (pc, instruction) pair to decode every cycle.
//
// Redirect sources:
//   - decode jump   (jump_en / jump_target). The jump instruction itself is
//                    valid, so nothing is squashed.
//   - execute branch (branch_en / branch_target). The instruction currently
//                    in fetch is wrong-path and is replaced by NOP in the
//                    same cycle.
// A decode stall holds the PC and lets the ROM re-read the same word.
//
// Ports:
//   clock          in   pipeline clock, all state updates on posedge
//   reset          in   synchronous, active-high
//   stall          in   decode hazard stall, hold pc and instruction
//   jump_en        in   decode-resolved jump taking effect this cycle
//   jump_target    in   absolute jump target (PC_W)
//   branch_en      in   execute-resolved taken branch / jr this cycle
//   branch_target  in   absolute branch target (PC_W)
//   imem_addr      out  next-fetch address to the synchronous ROM (PC_W)
//   imem_data      in   ROM word addressed at the previous posedge (32)
//   pc             out  address of the instruction presented to decode
//   instruction    out  instruction presented to decode (32)
//   fetch_count    out  number of instructions handed to decode (32)
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter int          PC_W = 12,
   parameter logic [31:0] NOP  = 32'h0000_0000
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            stall,
   input  logic            jump_en,
   input  logic [PC_W-1:0] jump_target,
   input  logic            branch_en,
   input  logic [PC_W-1:0] branch_target,
   output logic [PC_W-1:0] imem_addr,
   input  logic [31:0]     imem_data,
   output logic [PC_W-1:0] pc,
   output logic [31:0]     instruction,
   output logic [31:0]     fetch_count
);

   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] next_pc;
   logic            deliver;

   // Next-address select. A branch from execute outranks the stall because the
   // stalled instruction is wrong-path anyway; a decode jump is ignored under
   // stall and re-asserted by decode once the stall clears.
   // NOTE: next_pc gets a default before the priority chain so every path
   // assigns it and no latch can be inferred.
   always_comb begin
      next_pc = pc_q + PC_ONE;
      if (reset) begin
         next_pc = '0;
      end else if (branch_en) begin
         next_pc = branch_target;
      end else if (stall) begin
         next_pc = pc_q;
      end else if (jump_en) begin
         next_pc = jump_target;
      end
   end

   // The ROM samples the same address the PC register loads, so imem_data and
   // pc_q stay aligned with no extra bubble. imem_data never feeds next_pc.
   assign imem_addr = next_pc;

   // Wrong-path squash is combinational so the NOP reaches decode's D/X latch
   // on the same edge that applies the redirect.
   assign pc          = pc_q;
   assign instruction = (reset || branch_en) ? NOP : imem_data;

   // A valid instruction is handed to decode on every edge that is not reset,
   // not a stall and not a squash.
   assign deliver = !stall && !branch_en;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      pc_q <= next_pc;
      if (reset) begin
         fetch_count <= 32'd0;
      end else if (deliver) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. A behavioural synchronous ROM holds
// mem[i] = i + 100. Inputs change 1 time unit after a rising edge and outputs
// are sampled in that same quiet window, away from the clock edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   localparam int          PC_W = 12;
   localparam logic [31:0] NOP  = 32'h0000_0000;

   logic            clock;
   logic            reset;
   logic            stall;
   logic            jump_en;
   logic [PC_W-1:0] jump_target;
   logic            branch_en;
   logic [PC_W-1:0] branch_target;
   logic [PC_W-1:0] imem_addr;
   logic [31:0]     imem_data;
   logic [PC_W-1:0] pc;
   logic [31:0]     instruction;
   logic [31:0]     fetch_count;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:(1<<PC_W)-1];

   fetch_stage #(.PC_W(PC_W), .NOP(NOP)) dut (
      .clock         (clock),
      .reset         (reset),
      .stall         (stall),
      .jump_en       (jump_en),
      .jump_target   (jump_target),
      .branch_en     (branch_en),
      .branch_target (branch_target),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .pc            (pc),
      .instruction   (instruction),
      .fetch_count   (fetch_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous ROM: output is the word at the address sampled last edge.
   always @(posedge clock) imem_data <= mem[imem_addr];

   task tick;
      @(posedge clock);
      #1;
   endtask

   task idle_inputs;
      stall         = 1'b0;
      jump_en       = 1'b0;
      jump_target   = '0;
      branch_en     = 1'b0;
      branch_target = '0;
   endtask

   // Two reset edges, then release; afterwards pc=0, instruction=100.
   task do_reset;
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   task test_reset;
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      checks++; if (instruction !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", instruction, NOP); end
      checks++; if (imem_addr !== 12'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", imem_addr); end
      checks++; if (pc !== 12'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", pc); end
      checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fetch_count); end
      reset = 1'b0;
      #1;
      checks++; if (instruction !== 32'd100) begin errors++; $display("FAIL reset_first_instr got %0d want 100", instruction); end
   endtask

   task test_sequential;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         checks++; if (pc !== 12'(i)) begin errors++; $display("FAIL seq_pc[%0d] got %0d want %0d", i, pc, i); end
         checks++; if (instruction !== 32'(i + 100)) begin errors++; $display("FAIL seq_instr[%0d] got %0d want %0d", i, instruction, i + 100); end
         checks++; if (imem_addr !== 12'(i + 1)) begin errors++; $display("FAIL seq_addr[%0d] got %0d want %0d", i, imem_addr, i + 1); end
         tick();
      end
      checks++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL seq_count got %0d want 5", fetch_count); end
   endtask

   task test_stall;
      do_reset();
      tick(); tick(); tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         // A jump during stall must be ignored.
         jump_en     = (i == 1);
         jump_target = 12'd40;
         #1;
         checks++; if (imem_addr !== 12'd3) begin errors++; $display("FAIL stall_addr[%0d] got %0d want 3", i, imem_addr); end
         tick();
         checks++; if (pc !== 12'd3) begin errors++; $display("FAIL stall_pc[%0d] got %0d want 3", i, pc); end
         checks++; if (instruction !== 32'd103) begin errors++; $display("FAIL stall_instr[%0d] got %0d want 103", i, instruction); end
         checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL stall_count[%0d] got %0d want 3", i, fetch_count); end
      end
      stall   = 1'b0;
      jump_en = 1'b0;
      tick();
      checks++; if (pc !== 12'd4) begin errors++; $display("FAIL stall_release_pc got %0d want 4", pc); end
      checks++; if (instruction !== 32'd104) begin errors++; $display("FAIL stall_release_instr got %0d want 104", instruction); end
      checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL stall_release_count got %0d want 4", fetch_count); end
   endtask

   task test_jump;
      do_reset();
      tick(); tick();
      jump_en     = 1'b1;
      jump_target = 12'd40;
      #1;
      checks++; if (instruction !== 32'd102) begin errors++; $display("FAIL jump_no_squash got %0d want 102", instruction); end
      checks++; if (imem_addr !== 12'd40) begin errors++; $display("FAIL jump_addr got %0d want 40", imem_addr); end
      tick();
      jump_en = 1'b0;
      #1;
      checks++; if (pc !== 12'd40) begin errors++; $display("FAIL jump_pc got %0d want 40", pc); end
      checks++; if (instruction !== 32'd140) begin errors++; $display("FAIL jump_instr got %0d want 140", instruction); end
      checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL jump_count got %0d want 3", fetch_count); end
   endtask

   task test_branch;
      do_reset();
      for (int i = 0; i < 6; i++) tick();
      branch_en     = 1'b1;
      branch_target = 12'd20;
      #1;
      checks++; if (instruction !== NOP) begin errors++; $display("FAIL branch_squash got %h want %h", instruction, NOP); end
      checks++; if (imem_addr !== 12'd20) begin errors++; $display("FAIL branch_addr got %0d want 20", imem_addr); end
      tick();
      branch_en = 1'b0;
      #1;
      checks++; if (pc !== 12'd20) begin errors++; $display("FAIL branch_pc got %0d want 20", pc); end
      checks++; if (instruction !== 32'd120) begin errors++; $display("FAIL branch_instr got %0d want 120", instruction); end
      checks++; if (fetch_count !== 32'd6) begin errors++; $display("FAIL branch_count got %0d want 6", fetch_count); end
      tick();
      // Now at pc=21: branch, jump and stall together; branch must win.
      branch_en     = 1'b1;
      branch_target = 12'd20;
      jump_en       = 1'b1;
      jump_target   = 12'd50;
      stall         = 1'b1;
      #1;
      checks++; if (instruction !== NOP) begin errors++; $display("FAIL combo_squash got %h want %h", instruction, NOP); end
      tick();
      idle_inputs();
      #1;
      checks++; if (pc !== 12'd20) begin errors++; $display("FAIL combo_pc got %0d want 20", pc); end
      checks++; if (instruction !== 32'd120) begin errors++; $display("FAIL combo_instr got %0d want 120", instruction); end
      checks++; if (fetch_count !== 32'd7) begin errors++; $display("FAIL combo_count got %0d want 7", fetch_count); end
   endtask

   task test_wrap;
      do_reset();
      jump_en     = 1'b1;
      jump_target = 12'd4095;
      tick();
      jump_en = 1'b0;
      #1;
      checks++; if (pc !== 12'd4095) begin errors++; $display("FAIL wrap_pc_top got %0d want 4095", pc); end
      checks++; if (instruction !== 32'd4195) begin errors++; $display("FAIL wrap_instr_top got %0d want 4195", instruction); end
      checks++; if (imem_addr !== 12'd0) begin errors++; $display("FAIL wrap_addr got %0d want 0", imem_addr); end
      tick();
      checks++; if (pc !== 12'd0) begin errors++; $display("FAIL wrap_pc_zero got %0d want 0", pc); end
      checks++; if (instruction !== 32'd100) begin errors++; $display("FAIL wrap_instr_zero got %0d want 100", instruction); end
   endtask

   task test_reset_mid;
      do_reset();
      for (int i = 0; i < 9; i++) tick();
      checks++; if (pc !== 12'd9) begin errors++; $display("FAIL mid_pre_pc got %0d want 9", pc); end
      stall         = 1'b1;
      branch_en     = 1'b0;
      jump_en       = 1'b1;
      jump_target   = 12'd77;
      reset         = 1'b1;
      #1;
      checks++; if (instruction !== NOP) begin errors++; $display("FAIL mid_instr got %h want %h", instruction, NOP); end
      checks++; if (imem_addr !== 12'd0) begin errors++; $display("FAIL mid_addr got %0d want 0", imem_addr); end
      tick();
      reset = 1'b0;
      idle_inputs();
      #1;
      checks++; if (pc !== 12'd0) begin errors++; $display("FAIL mid_pc got %0d want 0", pc); end
      checks++; if (instruction !== 32'd100) begin errors++; $display("FAIL mid_after_instr got %0d want 100", instruction); end
      checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL mid_count got %0d want 0", fetch_count); end
   endtask

   initial begin
      for (int i = 0; i < (1 << PC_W); i++) mem[i] = 32'(i + 100);
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_sequential();
      test_stall();
      test_jump();
      test_branch();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
